// File: rtl/prio_arb_pkg.sv
// Shared types and defaults for the N-channel priority arbiter.
package prio_arb_pkg;

   localparam int unsigned PRIO_ARB_N = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc_n.sv
// Rotating priority search: index ptr has top priority, then ptr-1, ... wrapping 0 -> N-1.
module prio_enc_n
   import prio_arb_pkg::*;
#(
   parameter int unsigned N = PRIO_ARB_N,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   logic [W-1:0] cand;

   // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      cand   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = W'((32'(ptr) + i + 1) % N);
         if (req[cand]) begin
            any          = 1'b1;
            idx          = cand;
            onehot       = '0;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered N-channel priority arbiter holding each grant until ack.
// Define PRIO_ARB_RR_EN for round-robin; otherwise fixed priority, highest index wins.
module prio_arbiter_n
   import prio_arb_pkg::*;
#(
   parameter int unsigned N = PRIO_ARB_N,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic         valid,
   output logic [N-1:0] grant,
   output logic [W-1:0] y
);

   state_t       state;
   logic [W-1:0] ptr;
   logic         win_any;
   logic [W-1:0] win_idx;
   logic [N-1:0] win_onehot;

   prio_enc_n #(
      .N (N),
      .W (W)
   ) u_enc (
      .req    (req),
      .ptr    (ptr),
      .any    (win_any),
      .idx    (win_idx),
      .onehot (win_onehot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         valid <= 1'b0;
         grant <= '0;
         y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state <= BUSY;
                  valid <= 1'b1;
                  grant <= win_onehot;
                  y     <= win_idx;
               end
            end
            BUSY: begin
               if (ack) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  grant <= '0;
                  y     <= '0;
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               grant <= '0;
               y     <= '0;
            end
         endcase
      end
   end

`ifdef PRIO_ARB_RR_EN
   // y still holds the winner at the ack edge, so it drives the pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= W'(N - 1);
      end else if (state == BUSY && ack) begin
         ptr <= (y == '0) ? W'(N - 1) : y - 1'b1;
      end
   end
`else
   assign ptr = W'(N - 1);
`endif

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Directed self-checking bench for prio_arbiter_n with N=4 (both PRIO_ARB_RR_EN builds).
module tb_prio_arbiter_n;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       ack;
   logic       valid;
   logic [3:0] grant;
   logic [1:0] y;

   int unsigned checks = 0;
   int unsigned errors = 0;

   prio_arbiter_n #(
      .N (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .ack   (ack),
      .valid (valid),
      .grant (grant),
      .y     (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [3:0] g, input logic [1:0] yy);
      check({tag, ".valid"}, 32'(valid), 32'(v));
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".y"}, 32'(y), 32'(yy));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

`ifdef PRIO_ARB_RR_EN
   logic [3:0] rr_g [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
   logic [1:0] rr_y [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
   logic [3:0] rr_g [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
   logic [1:0] rr_y [5] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif

   initial begin
      rst = 1'b1;
      req = '0;
      ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      expect_out("reset", 1'b0, 4'b0000, 2'd0);

      // Idle with ack pulses: nothing may be granted.
      for (int i = 0; i < 3; i++) begin
         ack = i[0];
         step();
         expect_out("idle", 1'b0, 4'b0000, 2'd0);
      end
      ack = 1'b0;

      // Highest index wins first; grant frozen while req changes.
      req = 4'b1111;
      step();
      expect_out("first", 1'b1, 4'b1000, 2'd3);
      req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out("hold", 1'b1, 4'b1000, 2'd3);
      end
      ack = 1'b1;
      step();
      expect_out("ackdrop", 1'b0, 4'b0000, 2'd0);
      ack = 1'b0;

      // Rotation with req held high, ack every BUSY cycle.
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out("rr.grant", 1'b1, rr_g[i], rr_y[i]);
         ack = 1'b1;
         step();
         expect_out("rr.idle", 1'b0, 4'b0000, 2'd0);
         ack = 1'b0;
      end

      // Serving channel 0 wraps the pointer to 3.
      do_reset();
      req = 4'b0001;
      step();
      expect_out("wrap.g0", 1'b1, 4'b0001, 2'd0);
      ack = 1'b1;
      req = 4'b1001;
      step();
      expect_out("wrap.ack", 1'b0, 4'b0000, 2'd0);
      ack = 1'b0;
      step();
      expect_out("wrap.g3", 1'b1, 4'b1000, 2'd3);
      ack = 1'b1;
      step();
      ack = 1'b0;

      // Reset during BUSY drops the grant and restores ptr=3.
      req = 4'b0100;
      step();
      expect_out("mid.g2", 1'b1, 4'b0100, 2'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_out("mid.rst", 1'b0, 4'b0000, 2'd0);
      req = 4'b0110;
      step();
      expect_out("mid.after", 1'b1, 4'b0100, 2'd2);

      // Simultaneous rst and ack: rst wins, ptr back to 3.
      rst = 1'b1;
      ack = 1'b1;
      step();
      rst = 1'b0;
      ack = 1'b0;
      expect_out("rstack", 1'b0, 4'b0000, 2'd0);
      req = 4'b1100;
      step();
      expect_out("rstack.g", 1'b1, 4'b1000, 2'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
